// File: rtl/bus_drvr_fifo_bank.sv
// Bank of independent show-ahead FIFOs, one per (bus bit, driver) channel, c = b*drvrs + d.
// Optional per-channel saturating dropped-push counters: define BUS_FIFO_DROP_CNT_EN.
module bus_drvr_fifo_bank #(
    parameter int pckg_sz = 16,
    parameter int drvrs   = 4,
    parameter int bits    = 1,
    parameter int depth   = 8,
    localparam int NCH    = bits * drvrs,
    localparam int CW     = $clog2(depth + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH-1:0]         tb_push,
    input  logic [NCH*pckg_sz-1:0] tb_data,
    input  logic [NCH-1:0]         pop,
    input  logic                   clr_flags,
    output logic [NCH-1:0]         pndng,
    output logic [NCH*pckg_sz-1:0] D_pop,
    output logic [NCH-1:0]         full,
    output logic [NCH*CW-1:0]      count,
    output logic [NCH-1:0]         ovf,
`ifdef BUS_FIFO_DROP_CNT_EN
    output logic [NCH-1:0]         udf,
    output logic [NCH*8-1:0]       drop_cnt
`else
    output logic [NCH-1:0]         udf
`endif
);

    localparam int PW = $clog2(depth);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [pckg_sz-1:0] mem [depth];
        logic [PW-1:0]      wr_ptr, rd_ptr;
        logic [CW-1:0]      cnt;
        logic               ovf_r, udf_r;
        logic               is_full, is_empty;
        logic               do_push, do_pop, ovf_ev, udf_ev;

        // A pop on a full FIFO frees the slot the same-cycle push needs.
        always_comb begin
            is_full  = (cnt == CW'(depth));
            is_empty = (cnt == '0);
            do_pop   = pop[c] && !is_empty;
            do_push  = tb_push[c] && (!is_full || do_pop);
            ovf_ev   = tb_push[c] && is_full && !pop[c];
            udf_ev   = pop[c] && is_empty;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf_r  <= 1'b0;
                udf_r  <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= ptr_inc(wr_ptr);
                if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (do_push && !do_pop)      cnt <= cnt + 1'b1;
                else if (do_pop && !do_push) cnt <= cnt - 1'b1;
                // A new event in the clearing cycle survives the clear.
                ovf_r <= (clr_flags ? 1'b0 : ovf_r) | ovf_ev;
                udf_r <= (clr_flags ? 1'b0 : udf_r) | udf_ev;
            end
        end

        // Storage carries no reset; the empty mask keeps D_pop defined.
        always_ff @(posedge clock) begin
            if (!reset && do_push) mem[wr_ptr] <= tb_data[c*pckg_sz +: pckg_sz];
        end

        assign pndng[c]                   = !is_empty;
        assign full[c]                    = is_full;
        assign count[c*CW +: CW]          = cnt;
        assign ovf[c]                     = ovf_r;
        assign udf[c]                     = udf_r;
        assign D_pop[c*pckg_sz +: pckg_sz] = is_empty ? '0 : mem[rd_ptr];

`ifdef BUS_FIFO_DROP_CNT_EN
        logic [7:0] drop;

        always_ff @(posedge clock) begin
            if (reset) begin
                drop <= '0;
            end else if (clr_flags) begin
                drop <= ovf_ev ? 8'd1 : 8'd0;
            end else if (ovf_ev && drop != 8'hFF) begin
                drop <= drop + 1'b1;
            end
        end

        assign drop_cnt[c*8 +: 8] = drop;
`endif
    end

endmodule

// File: tb/tb_bus_drvr_fifo_bank.sv
// Scoreboard bench for bus_drvr_fifo_bank with default parameters (4 channels, depth 8).
// Define BUS_FIFO_DROP_CNT_EN to also exercise the dropped-push counters.
module tb_bus_drvr_fifo_bank;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int CW  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    tb_push = '0;
    logic [NCH*16-1:0] tb_data = '0;
    logic [NCH-1:0]    pop = '0;
    logic              clr_flags = 1'b0;
    logic [NCH-1:0]    pndng, full, ovf, udf;
    logic [NCH*16-1:0] D_pop;
    logic [NCH*CW-1:0] count;
`ifdef BUS_FIFO_DROP_CNT_EN
    logic [NCH*8-1:0]  drop_cnt;
`endif

    bus_drvr_fifo_bank dut (
        .clock(clock), .reset(reset), .tb_push(tb_push), .tb_data(tb_data),
        .pop(pop), .clr_flags(clr_flags), .pndng(pndng), .D_pop(D_pop),
        .full(full), .count(count), .ovf(ovf),
`ifdef BUS_FIFO_DROP_CNT_EN
        .udf(udf), .drop_cnt(drop_cnt)
`else
        .udf(udf)
`endif
    );

    always #5 clock = ~clock;

    logic [15:0] sb [NCH][$];
    bit          m_ovf [NCH];
    bit          m_udf [NCH];
    int          m_drop [NCH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            int sz = sb[c].size();
            chk($sformatf("count%0d", c), 32'(count[c*CW +: CW]), sz);
            chk($sformatf("pndng%0d", c), 32'(pndng[c]), 32'(sz != 0));
            chk($sformatf("full%0d", c), 32'(full[c]), 32'(sz == DEP));
            chk($sformatf("ovf%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
            chk($sformatf("udf%0d", c), 32'(udf[c]), 32'(m_udf[c]));
            chk($sformatf("dpop%0d", c), 32'(D_pop[c*16 +: 16]), (sz != 0) ? 32'(sb[c][0]) : 32'h0);
`ifdef BUS_FIFO_DROP_CNT_EN
            chk($sformatf("drop%0d", c), 32'(drop_cnt[c*8 +: 8]), m_drop[c]);
`endif
        end
    endtask

    task automatic drive(input logic [NCH-1:0] pu, input logic [NCH-1:0] po,
                         input logic [NCH*16-1:0] dat, input logic clr);
        tb_push = pu; pop = po; tb_data = dat; clr_flags = clr;
        for (int c = 0; c < NCH; c++) begin
            int          sz = sb[c].size();
            bit          oe = pu[c] && (sz == DEP) && !po[c];
            bit          ue = po[c] && (sz == 0);
            logic [15:0] head;
            if (po[c] && sz > 0) begin
                head = sb[c].pop_front();
                chk($sformatf("head%0d", c), 32'(D_pop[c*16 +: 16]), 32'(head));
            end
            if (pu[c] && (sz < DEP || (po[c] && sz > 0))) sb[c].push_back(dat[c*16 +: 16]);
            m_ovf[c] = (clr ? 1'b0 : m_ovf[c]) | oe;
            m_udf[c] = (clr ? 1'b0 : m_udf[c]) | ue;
            if (clr)     m_drop[c] = oe ? 1 : 0;
            else if (oe) m_drop[c] = (m_drop[c] == 255) ? 255 : m_drop[c] + 1;
        end
        tick();
        tb_push = '0; pop = '0; clr_flags = 1'b0;
        check_all();
    endtask

    // Pushes during the reset cycle must be ignored.
    task automatic do_reset();
        reset = 1'b1; tb_push = '1; tb_data = {NCH{16'hDEAD}};
        tick();
        reset = 1'b0; tb_push = '0;
        for (int c = 0; c < NCH; c++) begin
            sb[c].delete();
            m_ovf[c] = 0; m_udf[c] = 0; m_drop[c] = 0;
        end
        check_all();
    endtask

    function automatic logic [NCH*16-1:0] on_ch(input int c, input logic [15:0] v);
        logic [NCH*16-1:0] r = '0;
        r[c*16 +: 16] = v;
        return r;
    endfunction

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++) drive('0, '0, '0, 1'b0);

        // Channel 2 ordered traffic
        for (int i = 1; i <= 3; i++) drive(4'b0100, '0, on_ch(2, 16'hA000 + 16'(i)), 1'b0);
        for (int i = 0; i < 3; i++) drive('0, 4'b0100, '0, 1'b0);
        chk("ch2_empty", 32'(pndng[2]), 32'h0);

        // Channel 0 overflow and flag clear
        for (int i = 0; i < 9; i++) drive(4'b0001, '0, on_ch(0, 16'h0B00 + 16'(i)), 1'b0);
        chk("ch0_full", 32'(full[0]), 32'h1);
        chk("ch0_ovf", 32'(ovf[0]), 32'h1);
        chk("ch0_cnt", 32'(count[0 +: CW]), 32'd8);
`ifdef BUS_FIFO_DROP_CNT_EN
        chk("ch0_drop1", 32'(drop_cnt[0 +: 8]), 32'd1);
        for (int i = 0; i < 260; i++) drive(4'b0001, '0, on_ch(0, 16'hEEEE), 1'b0);
        chk("ch0_drop_sat", 32'(drop_cnt[0 +: 8]), 32'd255);
`endif
        drive('0, '0, '0, 1'b1);
        chk("ch0_ovf_clr", 32'(ovf[0]), 32'h0);
        drive(4'b0001, '0, on_ch(0, 16'hEEEE), 1'b1);
        chk("ch0_ovf_set_wins", 32'(ovf[0]), 32'h1);

        // Channel 1 full: push+pop keeps it full
        for (int i = 0; i < 8; i++) drive(4'b0010, '0, on_ch(1, 16'h1100 + 16'(i)), 1'b0);
        drive(4'b0010, 4'b0010, on_ch(1, 16'h5555), 1'b0);
        chk("ch1_cnt", 32'(count[CW +: CW]), 32'd8);
        chk("ch1_ovf", 32'(ovf[1]), 32'h0);
        for (int i = 0; i < 7; i++) drive('0, 4'b0010, '0, 1'b0);
        chk("ch1_tail", 32'(D_pop[16 +: 16]), 32'h5555);

        // Channel 3 empty: push+pop
        drive(4'b1000, 4'b1000, on_ch(3, 16'h1234), 1'b0);
        chk("ch3_cnt", 32'(count[3*CW +: CW]), 32'd1);
        chk("ch3_dpop", 32'(D_pop[48 +: 16]), 32'h1234);
        chk("ch3_udf", 32'(udf[3]), 32'h1);

        // Wrap across pointers on channel 0, then reset with data held
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) drive(4'b0001, '0, on_ch(0, 16'(r*5 + i)), 1'b0);
            for (int i = 0; i < 5; i++) drive('0, 4'b0001, '0, 1'b0);
        end
        for (int i = 0; i < 5; i++) drive(4'b0001, '0, on_ch(0, 16'h0100 + 16'(i)), 1'b0);
        chk("pre_rst_cnt", 32'(count[0 +: CW]), 32'd5);
        do_reset();
        chk("post_rst_cnt", 32'(count[0 +: CW]), 32'd0);
        chk("post_rst_pndng", 32'(pndng[0]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
